// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit (shr, shra, shl, ror, rol) with start/busy/done handshake.
// Optional carry_out port enabled by defining SHIFT_CARRY_EN.
module shift_rotate_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [AW-1:0]    amt,
  output logic             busy,
  output logic             done,
`ifdef SHIFT_CARRY_EN
  output logic             carry_out,
`endif
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_SHR  = 3'b000,
    OP_SHRA = 3'b001,
    OP_SHL  = 3'b010,
    OP_ROR  = 3'b011,
    OP_ROL  = 3'b100
  } op_e;

  localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, result_q;
  logic [AW-1:0]      rem_q;
  logic [2:0]         op_q;
  logic               sign_q;
  logic [AW:0]        s;
  logic [WIDTH-1:0]   shifted;
  logic [2*WIDTH-1:0] wide;

  // Bits moved this cycle: never more than STEP, never past the remaining amount.
  always_comb begin
    s = ({1'b0, rem_q} < STEP_W) ? {1'b0, rem_q} : STEP_W;
  end

  always_comb begin
    wide    = '0;
    shifted = acc_q;
    case (op_q)
      OP_SHR:  shifted = acc_q >> s;
      OP_SHRA: begin
        wide    = {{WIDTH{sign_q}}, acc_q} >> s;
        shifted = wide[WIDTH-1:0];
      end
      OP_SHL:  shifted = acc_q << s;
      OP_ROR: begin
        wide    = {acc_q, acc_q} >> s;
        shifted = wide[WIDTH-1:0];
      end
      OP_ROL: begin
        wide    = {acc_q, acc_q} << s;
        shifted = wide[2*WIDTH-1:WIDTH];
      end
      default: shifted = acc_q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (amt != '0 && op <= OP_ROL) ? S_SHIFT : S_DONE;
      S_SHIFT: if ({1'b0, rem_q} == s) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // result is loaded on the edge entering DONE so it is valid while done is high.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      acc_q    <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          acc_q  <= a;
          rem_q  <= amt;
          op_q   <= op;
          sign_q <= a[WIDTH-1];
          if (state_d == S_DONE) result_q <= a;
        end
        S_SHIFT: begin
          acc_q <= shifted;
          rem_q <= rem_q - AW'(s);
          if (state_d == S_DONE) result_q <= shifted;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

`ifdef SHIFT_CARRY_EN
  localparam logic [AW:0] WIDTH_W = (AW+1)'(WIDTH);

  logic          carry_q, bit_out;
  logic [AW-1:0] lo_idx, hi_idx;

  // Right-moving ops lose bit s-1; left-moving ops lose bit WIDTH-s.
  always_comb begin
    lo_idx  = AW'(s - 1'b1);
    hi_idx  = AW'(WIDTH_W - s);
    bit_out = 1'b0;
    case (op_q)
      OP_SHR, OP_SHRA, OP_ROR: bit_out = acc_q[lo_idx];
      OP_SHL, OP_ROL:          bit_out = acc_q[hi_idx];
      default:                 bit_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      carry_q <= 1'b0;
    end else if (state_d == S_DONE) begin
      if (state_q == S_SHIFT)                carry_q <= bit_out;
      else if (state_q == S_IDLE && start)   carry_q <= 1'b0;
    end
  end

  assign carry_out = carry_q;
`endif

endmodule

// File: doc/shift_rotate_unit.md
Name: shift_rotate_unit

Overview:
Multi-cycle, parametrised shift/rotate execution unit for the Mini SRC datapath. It generalises the single-cycle 32-bit SHR ALU path to five operations (shr, shra, shl, ror, rol), configurable width and bits-per-cycle. It sits beside the ALU: operand A comes from Y, the amount comes from the bus, and the result is written to Zlow. It uses a start/busy/done handshake so the control unit can stall in T4 until done.

Parameters:
WIDTH, 32, operand/result width in bits; power of 2, at least 8.
STEP, 1, maximum bits shifted per clock; power of 2, from 1 to WIDTH.
AW, $clog2(WIDTH), width of the shift-amount field (derived; do not override).

Ports:
clk  in  1  system clock; all state updates on rising edge.
clr  in  1  asynchronous active-high reset.
start  in  1  request pulse; sampled only in IDLE.
op  in  3  000 shr, 001 shra, 010 shl, 011 ror, 100 rol; 101-111 pass-through.
a  in  WIDTH  operand; sampled on the accepting edge.
amt  in  AW  shift amount; the low AW bits of the bus, i.e. amt mod WIDTH.
busy  out  1  high in SHIFT and DONE.
done  out  1  one-cycle pulse; result valid.
result  out  WIDTH  registered result; held until the next accepted start.

Behaviour:
- Reset: clr=1 forces state=IDLE and busy=0, done=0, result=0, internal acc=0, rem=0. Reset applies immediately, including mid-operation. The aborted operation produces no done.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 on an edge: acc<=a, rem<=amt, op latched.
  - Next state is SHIFT if amt!=0 and op is 000-100; otherwise DONE.
- SHIFT, each edge:
  - s=min(STEP, rem); acc is shifted/rotated by s per the latched op; rem<=rem-s.
  - When rem==s (rem reaches 0), next state is DONE.
- DONE: done=1 and result=acc for exactly one cycle; next state IDLE.
- busy=1 exactly when state is SHIFT or DONE.
- Latency: done is high in cycle ceil(amt/STEP)+1 after the accepting edge. amt=0 or pass-through gives 1 cycle.
- Operation rules:
  - shr: zero fill.
  - shra: fill with latched a[WIDTH-1].
  - shl: zero fill.
  - ror/rol: bits wrap.
- start while busy is ignored; a, amt and op changes while busy have no effect.
- start high in the DONE cycle is ignored. A new operation can be accepted on the cycle after done (IDLE).
- start held continuously issues back-to-back operations, one per IDLE visit.
- result updates only in DONE. During SHIFT it still shows the previous result.

Optional Feature:
SHIFT_CARRY_EN: when defined, adds output port carry_out (1 bit, reset 0).
- carry_out is registered and updated with result in DONE.
- It holds the last bit shifted out (for ror/rol, the last bit wrapped around).
- It is 0 for amt=0 and for pass-through ops.
- With STEP>1, it is the final bit crossing the boundary.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- STEP=1, op=000, a=0x8000FA92, amt=10: done 11 cycles after accept, result=0x0020003E; with SHIFT_CARRY_EN, carry_out=1.
- op=001, a=0x8000FA92, amt=4 → 0xF8000FA9. op=010, a=0x595, amt=3 → 0x00002CA8.
- op=011, a=0x8000FA92, amt=4 → 0x28000FA9. op=100, a=0x8000FA92, amt=1 → 0x0001F525.
- STEP=4, op=000, a=0x8000FA92, amt=10: done on 4th cycle after accept, result=0x0020003E. amt=0: done 1 cycle later, result=a.
- Pulse start again mid-SHIFT with different a/amt: ignored, first result unchanged. Assert clr during SHIFT: busy=0, done never pulses, result=0.
- op=111, a=0x12345678, amt=7: done after 1 cycle, result=0x12345678, busy low the following cycle.
